mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access pipeline stage between execute and register write-back.
- Takes the execute result and load/store controls, and runs one data-memory transaction at a time over a req/ack handshake.
- Aligns and extends load data, and generates store byte enables.
- Drives the write-back stage's rd_sel/rd pair through a registered output; stalls upstream while a transaction is outstanding.

Parameters:
- WIDTH, 32, data/address width; byte-lane logic is defined for 32 only.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- halt  in  1  core halted; no new ops accepted.
- in_valid  in  1  execute presents an op this cycle.
- in_rd_sel  in  5  destination register index.
- in_alu  in  WIDTH  ALU result / effective address.
- in_store_data  in  WIDTH  rs2 value for stores.
- in_funct3  in  3  load/store size and sign code.
- in_load  in  1  op is a load.
- in_store  in  1  op is a store; in_load and in_store are never both high.
- stall  out  1  upstream must hold its op.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  WIDTH  word-aligned address ({in_alu[31:2],2'b00}).
- mem_wdata  out  WIDTH  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  transaction complete; mem_rdata valid this cycle.
- mem_rdata  in  WIDTH  read word.
- rd_sel  out  5  write-back destination; 0 = bubble.
- rd  out  WIDTH  write-back data.
- misaligned  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state IDLE; stall, mem_req, mem_we, misaligned, rd_sel, mem_be = 0; rd, mem_addr, mem_wdata = 0.
- Reset during WAIT abandons the outstanding transaction. A later mem_ack is ignored.
- State machine: IDLE, WAIT.
- stall = (state==WAIT). mem_req = (state==WAIT).
- mem_we/mem_addr/mem_wdata/mem_be are registered at acceptance and held constant through WAIT.
- IDLE, in_valid=1, halt=0 is an acceptance. On the next edge:
  - Non-memory op: rd_sel<=in_rd_sel, rd<=in_alu. Latency 1; stays IDLE.
  - Aligned load/store: latch the request, go to WAIT, rd_sel<=0.
  - Misaligned load/store: no request; misaligned<=1 for one cycle; rd_sel<=0; stays IDLE.
- IDLE otherwise (in_valid=0 or halt=1): rd_sel<=0 next edge. mem_ack in IDLE is ignored.
- WAIT, mem_ack=0: hold all request outputs; rd_sel stays 0; in_valid ignored.
- WAIT, mem_ack=1: next edge go to IDLE.
  - Load: rd_sel<=latched rd_sel, rd<=extended data.
  - Store: rd_sel<=0.
- halt during WAIT does not abort; the transaction completes normally.
- An ack in the same cycle mem_req first rises is legal. Minimum load latency is therefore 2 cycles from acceptance to rd valid.
- Load funct3:
  - 000 LB: sign-extend byte at lane addr[1:0].
  - 001 LH: sign-extend halfword at lane addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - Other codes are treated as LW.
- Byte/half lane select uses the latched in_alu[1:0].
- Store funct3:
  - 000 SB: be=4'b0001<<addr[1:0], wdata={4{byte}}.
  - 001 SH: be=addr[1]?4'b1100:4'b0011, wdata={2{half}}.
  - 010 and others SW: be=4'b1111, wdata=data.
  - Loads use be=4'b1111.
- Misaligned conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Byte accesses are never misaligned.
- A load with in_rd_sel=0 still performs the read; rd_sel presented as 0.

Test Plan:
- ALU op: in_valid=1, in_rd_sel=5, in_alu=0x1234 -> next cycle rd_sel=5, rd=0x1234, mem_req=0, stall=0.
- LB at 0x1003, ack one cycle after mem_req rises, mem_rdata=0x80AABBCC -> mem_addr=0x1000, be=4'b1111; rd=0xFFFFFF80; stall high exactly 2 cycles.
- LHU at 0x2002, mem_rdata=0x8001FFFF -> rd=0x00008001. LH at 0x2002, same mem_rdata -> rd=0xFFFF8001.
- SB at 0x3001, data=0x000000AB -> mem_we=1, be=4'b0010, wdata=0xABABABAB; rd_sel stays 0 throughout.
- LW at 0x4002 -> misaligned one cycle, no mem_req, rd_sel=0. SH at 0x4001 gives the same response.
- LW, ack withheld 4 cycles, reset asserted in cycle 3 -> next cycle IDLE, stall=0, mem_req=0; a later ack produces no rd_sel output.

Source files
------------

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Purpose  : Data-memory request/acknowledge bus between the memory-access
//            stage (master) and the data memory (slave).
// Revision : 1.0
// ============================================================================
interface mem_access_stage_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Pipeline stage between execute and write-back. It runs one
//            data-memory transaction at a time, aligns and extends load data,
//            and produces the registered rd_sel/rd write-back pair.
// Revision : 1.0
// ============================================================================
module mem_access_stage #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             halt,
    input  wire logic             in_valid,
    input  wire logic [4:0]       in_rd_sel,
    input  wire logic [WIDTH-1:0] in_alu,
    input  wire logic [WIDTH-1:0] in_store_data,
    input  wire logic [2:0]       in_funct3,
    input  wire logic             in_load,
    input  wire logic             in_store,
    output logic                  stall,
    mem_access_stage_if.master    mem,
    output logic [4:0]            rd_sel,
    output logic [WIDTH-1:0]      rd,
    output logic                  misaligned
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] c_be_all = 4'b1111;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [4:0]       r_rd_sel;
    logic [WIDTH-1:0] r_rd;
    logic             r_misaligned;
    logic             r_we;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [3:0]       r_be;
    logic [2:0]       r_funct3;
    logic [1:0]       r_lane;
    logic             r_load;
    logic [4:0]       r_pend_rd_sel;

    logic [4:0]       w_rd_sel_nxt;
    logic [WIDTH-1:0] w_rd_nxt;
    logic             w_misaligned_nxt;
    logic             w_latch;

    logic             w_is_mem;
    logic             w_size_byte;
    logic             w_size_half;
    logic             w_bad_align;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;

    logic [7:0]       w_ld_byte;
    logic [15:0]      w_ld_half;
    logic [WIDTH-1:0] w_ld_data;

    // ------------------------------------------------------------------
    // Access-size decode. Loads use funct3[2] as the unsigned flag, so the
    // size lives in funct3[1:0]; stores with any code above SH are words.
    // ------------------------------------------------------------------
    assign w_is_mem = in_load | in_store;

    always_comb begin
        w_size_byte = 1'b0;
        w_size_half = 1'b0;
        if (in_store) begin
            w_size_byte = (in_funct3 == 3'b000);
            w_size_half = (in_funct3 == 3'b001);
        end else begin
            w_size_byte = (in_funct3[1:0] == 2'b00);
            w_size_half = (in_funct3[1:0] == 2'b01);
        end
    end

    assign w_bad_align = w_is_mem &
                         ((w_size_half & in_alu[0]) |
                          (~w_size_byte & ~w_size_half & (in_alu[1:0] != 2'b00)));

    // ------------------------------------------------------------------
    // Store lane formatting: data is replicated across all lanes and the
    // byte enables pick out the addressed ones.
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = c_be_all;
        w_wdata = '0;
        if (in_store) begin
            if (w_size_byte) begin
                w_be    = 4'b0001 << in_alu[1:0];
                w_wdata = {(WIDTH/8){in_store_data[7:0]}};
            end else if (w_size_half) begin
                w_be    = in_alu[1] ? 4'b1100 : 4'b0011;
                w_wdata = {(WIDTH/16){in_store_data[15:0]}};
            end else begin
                w_be    = c_be_all;
                w_wdata = in_store_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension using the lane captured at acceptance.
    // ------------------------------------------------------------------
    assign w_ld_byte = mem.mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_ld_half = mem.mem_rdata[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_data = mem.mem_rdata;
        case (r_funct3)
            3'b000:  w_ld_data = {{(WIDTH-8){w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_data = {{(WIDTH-16){w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_data = {{(WIDTH-8){1'b0}}, w_ld_byte};
            3'b101:  w_ld_data = {{(WIDTH-16){1'b0}}, w_ld_half};
            default: w_ld_data = mem.mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and next values of the registered outputs.
    // rd_sel defaults to a bubble; only an ALU op or a completing load
    // presents a destination.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_rd_sel_nxt     = 5'd0;
        w_rd_nxt         = r_rd;
        w_misaligned_nxt = 1'b0;
        w_latch          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid && !halt) begin
                    if (!w_is_mem) begin
                        w_rd_sel_nxt = in_rd_sel;
                        w_rd_nxt     = in_alu;
                    end else if (w_bad_align) begin
                        w_misaligned_nxt = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem.mem_ack) begin
                    w_state_nxt = S_IDLE;
                    if (r_load) begin
                        w_rd_sel_nxt = r_pend_rd_sel;
                        w_rd_nxt     = w_ld_data;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_sel      <= 5'd0;
            r_rd          <= '0;
            r_misaligned  <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be          <= 4'b0000;
            r_funct3      <= 3'b000;
            r_lane        <= 2'b00;
            r_load        <= 1'b0;
            r_pend_rd_sel <= 5'd0;
        end else begin
            r_rd_sel     <= w_rd_sel_nxt;
            r_rd         <= w_rd_nxt;
            r_misaligned <= w_misaligned_nxt;
            if (w_latch) begin
                r_we          <= in_store;
                r_addr        <= {in_alu[WIDTH-1:2], 2'b00};
                r_wdata       <= w_wdata;
                r_be          <= w_be;
                r_funct3      <= in_funct3;
                r_lane        <= in_alu[1:0];
                r_load        <= in_load;
                r_pend_rd_sel <= in_rd_sel;
            end
        end
    end

    assign stall         = (r_state == S_WAIT);
    assign mem.mem_req   = (r_state == S_WAIT);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_be    = r_be;
    assign rd_sel        = r_rd_sel;
    assign rd            = r_rd;
    assign misaligned    = r_misaligned;

endmodule
`default_nettype wire
